// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state encoding and message-length helper.
package midi_pkg;

  // Channel-message status nibbles (status byte bits [7:4])
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CH_AT    = 4'hD;
  localparam logic [3:0] BEND     = 4'hE;

  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;
  localparam logic [7:0] VIB_CENTER       = 8'h40;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2
  } state_t;

  // Number of data bytes carried by a channel message, keyed on the status nibble
  function automatic logic [1:0] msg_len(input logic [3:0] status_nib);
    case (status_nib)
      PROG, CH_AT: msg_len = 2'd1;
      default:     msg_len = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/midi_note_decoder.sv
// Monophonic MIDI parser: turns the received byte stream into gate/note/volume,
// pitch-bend and waveform-select controls for a single voice.
module midi_note_decoder
  import midi_pkg::*;
#(
  parameter int CHANNEL = 0,
  parameter bit OMNI    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [15:0] note_vol,
  output logic [7:0]  vibrato,
  output logic [1:0]  wave_select,
  output logic        msg_strobe
);

  localparam logic [3:0] CHAN = 4'(CHANNEL);

  state_t      state_q, state_d;
  logic [7:0]  status_q, status_d;   // running status; 00 means none
  logic [6:0]  d1_q, d1_d;

  logic [15:0] note_vol_q, note_vol_d;
  logic [7:0]  vibrato_q, vibrato_d;
  logic [1:0]  wave_q, wave_d;
  logic        strobe_q, strobe_d;

  logic        is_data;
  logic        one_byte_msg;
  logic        complete;
  logic        channel_ok;
  logic [6:0]  arg1;
  logic [6:0]  arg2;

  assign is_data      = byte_valid && !byte_in[7];
  assign one_byte_msg = (msg_len(status_q[7:4]) == 2'd1);
  // A data byte that finishes the message currently being parsed
  assign complete     = is_data &&
                        (((state_q == WAIT_D1) && one_byte_msg) || (state_q == WAIT_D2));
  assign channel_ok   = OMNI || (status_q[3:0] == CHAN);
  // For one-byte messages the only argument is the byte arriving right now
  assign arg1         = one_byte_msg ? byte_in[6:0] : d1_q;
  assign arg2         = byte_in[6:0];

  // Parser state, running status and first data byte registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      status_q <= 8'h00;
      d1_q     <= 7'h00;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      d1_q     <= d1_d;
    end
  end

  // Next-state: classify the incoming byte and advance the parser
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    d1_d     = d1_q;
    if (byte_valid) begin
      if (byte_in >= 8'hF8) begin
        // Real-time bytes are transparent to the parser
        state_d = state_q;
      end else if (byte_in >= 8'hF0) begin
        // System common / SysEx kills running status until the next channel status
        state_d  = IDLE;
        status_d = 8'h00;
      end else if (byte_in[7]) begin
        // Channel status, possibly abandoning a partial message
        state_d  = WAIT_D1;
        status_d = byte_in;
      end else begin
        case (state_q)
          WAIT_D1: begin
            d1_d    = byte_in[6:0];
            state_d = one_byte_msg ? WAIT_D1 : WAIT_D2;
          end
          WAIT_D2: state_d = WAIT_D1;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Output: execute a completed, channel-matching message against the voice
  always_comb begin
    note_vol_d = note_vol_q;
    vibrato_d  = vibrato_q;
    wave_d     = wave_q;
    strobe_d   = 1'b0;
    if (complete && channel_ok) begin
      case (status_q[7:4])
        NOTE_ON, NOTE_OFF: begin
          if ((status_q[7:4] == NOTE_ON) && (arg2 != 7'd0)) begin
            // Replicate vel[6] into the LSB so full velocity reaches 255
            note_vol_d = {1'b1, arg1, arg2, arg2[6]};
            strobe_d   = 1'b1;
          end else if (arg1 == note_vol_q[14:8]) begin
            // Release only the sounding note; others are ignored silently
            note_vol_d = {1'b0, arg1, 8'h00};
            strobe_d   = 1'b1;
          end
        end
        CC: begin
          if (arg1 == CC_ALL_NOTES_OFF) begin
            note_vol_d = {1'b0, note_vol_q[14:8], 8'h00};
            strobe_d   = 1'b1;
          end
        end
        PROG: begin
          wave_d   = arg1[1:0];
          strobe_d = 1'b1;
        end
        BEND: begin
          // Only the MSB matters for vibrato depth; LSB is dropped
          vibrato_d = {1'b0, arg2};
          strobe_d  = 1'b1;
        end
        default: strobe_d = 1'b0;  // POLY_AT and CH_AT are length-parsed only
      endcase
    end
  end

  // Voice control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      note_vol_q <= 16'h0000;
      vibrato_q  <= VIB_CENTER;
      wave_q     <= 2'b00;
      strobe_q   <= 1'b0;
    end else begin
      note_vol_q <= note_vol_d;
      vibrato_q  <= vibrato_d;
      wave_q     <= wave_d;
      strobe_q   <= strobe_d;
    end
  end

  assign note_vol    = note_vol_q;
  assign vibrato     = vibrato_q;
  assign wave_select = wave_q;
  assign msg_strobe  = strobe_q;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Directed bench for midi_note_decoder: channel-0 instance plus an OMNI instance.
module tb_midi_note_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;

  logic [15:0] note_vol0, note_vol1;
  logic [7:0]  vibrato0, vibrato1;
  logic [1:0]  wave0, wave1;
  logic        strobe0, strobe1;

  int checks = 0;
  int fails  = 0;
  int cnt0   = 0;

  always #5 clk = ~clk;

  midi_note_decoder #(.CHANNEL(0), .OMNI(1'b0)) dut0 (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .note_vol(note_vol0), .vibrato(vibrato0), .wave_select(wave0), .msg_strobe(strobe0)
  );

  midi_note_decoder #(.CHANNEL(0), .OMNI(1'b1)) dut1 (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .note_vol(note_vol1), .vibrato(vibrato1), .wave_select(wave1), .msg_strobe(strobe1)
  );

  // Strobe counter for the channel-0 instance, sampled away from the edge
  always @(posedge clk) begin
    #2;
    if (strobe0 === 1'b1) cnt0++;
  end

  // Present one byte for one cycle; returns at the following falling edge
  task automatic send(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    $display("tx byte %02h  note_vol=%04h vib=%02h wave=%0d strobe=%0b",
             b, note_vol0, vibrato0, wave0, strobe0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cnt0 = 0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) @(negedge clk);
    checks++; if (note_vol0 !== 16'h0000) begin fails++; $display("FAIL reset_note_vol: got %04h want 0000", note_vol0); end
    checks++; if (vibrato0 !== 8'h40) begin fails++; $display("FAIL reset_vibrato: got %02h want 40", vibrato0); end
    checks++; if (wave0 !== 2'b00) begin fails++; $display("FAIL reset_wave: got %0d want 0", wave0); end
    checks++; if (strobe0 !== 1'b0) begin fails++; $display("FAIL reset_strobe: got %0b want 0", strobe0); end
  endtask

  task automatic test_note_on();
    do_reset();
    send(8'h90); send(8'h3C);
    checks++; if (strobe0 !== 1'b0) begin fails++; $display("FAIL note_on_early_strobe: got %0b want 0", strobe0); end
    send(8'h7F);
    checks++; if (note_vol0 !== 16'hBCFF) begin fails++; $display("FAIL note_on_vol: got %04h want BCFF", note_vol0); end
    checks++; if (strobe0 !== 1'b1) begin fails++; $display("FAIL note_on_strobe: got %0b want 1", strobe0); end
    @(negedge clk);
    checks++; if (strobe0 !== 1'b0) begin fails++; $display("FAIL note_on_strobe_width: got %0b want 0", strobe0); end
    repeat (2) @(negedge clk);
    checks++; if (cnt0 !== 1) begin fails++; $display("FAIL note_on_strobe_count: got %0d want 1", cnt0); end
  endtask

  task automatic test_running_status();
    do_reset();
    send(8'h90); send(8'h3C); send(8'h40);
    checks++; if (note_vol0 !== 16'hBC81) begin fails++; $display("FAIL rs_first: got %04h want BC81", note_vol0); end
    send(8'h3E); send(8'h20);
    // vel 0x20 -> {0100000, 0} = 0x40
    checks++; if (note_vol0 !== 16'hBE40) begin fails++; $display("FAIL rs_second: got %04h want BE40", note_vol0); end
    send(8'h3C); send(8'h00);
    checks++; if (note_vol0 !== 16'hBE40) begin fails++; $display("FAIL rs_unmatched_off: got %04h want BE40", note_vol0); end
    checks++; if (strobe0 !== 1'b0) begin fails++; $display("FAIL rs_unmatched_strobe: got %0b want 0", strobe0); end
    repeat (2) @(negedge clk);
    checks++; if (cnt0 !== 2) begin fails++; $display("FAIL rs_strobe_count: got %0d want 2", cnt0); end
    // Matching note-off via 8n keeps the note and clears gate/volume
    send(8'h80); send(8'h3E); send(8'h10);
    checks++; if (note_vol0 !== 16'h3E00) begin fails++; $display("FAIL note_off_match: got %04h want 3E00", note_vol0); end
  endtask

  task automatic test_realtime();
    do_reset();
    send(8'h90); send(8'h45); send(8'hF8);
    checks++; if (note_vol0 !== 16'h0000) begin fails++; $display("FAIL rt_no_effect: got %04h want 0000", note_vol0); end
    send(8'h64);
    checks++; if (note_vol0 !== 16'hC5C9) begin fails++; $display("FAIL rt_note: got %04h want C5C9", note_vol0); end
    repeat (2) @(negedge clk);
    checks++; if (cnt0 !== 1) begin fails++; $display("FAIL rt_strobe_count: got %0d want 1", cnt0); end
  endtask

  task automatic test_channel_filter();
    do_reset();
    send(8'h91); send(8'h3C); send(8'h7F);
    checks++; if (note_vol0 !== 16'h0000) begin fails++; $display("FAIL filter_ch0: got %04h want 0000", note_vol0); end
    checks++; if (note_vol1 !== 16'hBCFF) begin fails++; $display("FAIL filter_omni: got %04h want BCFF", note_vol1); end
    checks++; if (strobe1 !== 1'b1) begin fails++; $display("FAIL filter_omni_strobe: got %0b want 1", strobe1); end
    repeat (2) @(negedge clk);
    checks++; if (cnt0 !== 0) begin fails++; $display("FAIL filter_strobe_count: got %0d want 0", cnt0); end
  endtask

  task automatic test_controls();
    do_reset();
    send(8'hE0); send(8'h00); send(8'h7F);
    checks++; if (vibrato0 !== 8'h7F) begin fails++; $display("FAIL bend: got %02h want 7F", vibrato0); end
    send(8'hC0); send(8'h06);
    checks++; if (wave0 !== 2'd2) begin fails++; $display("FAIL program: got %0d want 2", wave0); end
    send(8'h03);  // running-status program change
    checks++; if (wave0 !== 2'd3) begin fails++; $display("FAIL program_rs: got %0d want 3", wave0); end
    repeat (2) @(negedge clk);
    cnt0 = 0;
    send(8'hF0); send(8'h3C); send(8'h7F); send(8'hF7);
    checks++; if (note_vol0 !== 16'h0000) begin fails++; $display("FAIL sysex_discard: got %04h want 0000", note_vol0); end
    checks++; if (vibrato0 !== 8'h7F) begin fails++; $display("FAIL sysex_vib: got %02h want 7F", vibrato0); end
    // Channel pressure and poly aftertouch are parsed then dropped
    send(8'hD0); send(8'h10); send(8'hA0); send(8'h3C); send(8'h20);
    // A mid-message status abandons the partial message
    send(8'h90); send(8'h40); send(8'hB0); send(8'h07); send(8'h10);
    checks++; if (note_vol0 !== 16'h0000) begin fails++; $display("FAIL abandon: got %04h want 0000", note_vol0); end
    repeat (2) @(negedge clk);
    checks++; if (cnt0 !== 0) begin fails++; $display("FAIL discard_strobe_count: got %0d want 0", cnt0); end
    send(8'h90); send(8'h40); send(8'h7F);
    checks++; if (note_vol0 !== 16'hC0FF) begin fails++; $display("FAIL pre_ano: got %04h want C0FF", note_vol0); end
    send(8'hB0); send(8'h7B); send(8'h00);
    checks++; if (note_vol0 !== 16'h4000) begin fails++; $display("FAIL all_notes_off: got %04h want 4000", note_vol0); end
  endtask

  task automatic test_reset_mid();
    send(8'h90); send(8'h3C);
    do_reset();
    checks++; if (note_vol0 !== 16'h0000) begin fails++; $display("FAIL rst_mid_note_vol: got %04h want 0000", note_vol0); end
    checks++; if (vibrato0 !== 8'h40) begin fails++; $display("FAIL rst_mid_vibrato: got %02h want 40", vibrato0); end
    checks++; if (wave0 !== 2'b00) begin fails++; $display("FAIL rst_mid_wave: got %0d want 0", wave0); end
    send(8'h7F);
    repeat (2) @(negedge clk);
    checks++; if (note_vol0 !== 16'h0000) begin fails++; $display("FAIL rst_mid_lone_data: got %04h want 0000", note_vol0); end
    checks++; if (cnt0 !== 0) begin fails++; $display("FAIL rst_mid_strobe_count: got %0d want 0", cnt0); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_note_on();
    test_running_status();
    test_realtime();
    test_channel_filter();
    test_controls();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
